// File: rtl/cpu_stoc_wbuf.sv
// Four-entry posted write buffer between the STOC cache-data driver and the cache data RAM.
// Stores are captured on the falling STOC_n strobe and drained in order over a CWREQ/CWACK handshake.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no request; moves to REQ when the buffer holds an entry
// REQ   | CWREQ high, head entry on CRAM outputs, waiting for CWACK
// RECOV | one dead cycle for RAM write-enable recovery
module cpu_stoc_wbuf (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        STOC_n,
  input  logic [15:0] CD_15_0,
  input  logic [9:0]  CA_9_0,
  input  logic        CWACK,
  output logic        CWREQ,
  output logic        CWE_n,
  output logic [15:0] CRAM_D_15_0,
  output logic [9:0]  CRAM_A_9_0,
  output logic        WBFULL_n,
  output logic        WBEMPTY,
  output logic [2:0]  WBCNT_2_0,
  output logic        WBOVF
);

  typedef enum logic [1:0] {IDLE, REQ, RECOV} drainStateT;

  drainStateT  state;
  logic        stocPrev;
  logic [25:0] mem [4];
  logic [1:0]  headPtr;
  logic [1:0]  tailPtr;
  logic [2:0]  count;
  logic [25:0] cramQ;
  logic        cwReq;
  logic        wbOvf;

  logic storeEvt;
  logic isFull;
  logic doPush;
  logic doPop;

  assign storeEvt = ~STOC_n & stocPrev;
  assign isFull   = (count == 3'd4);
  assign doPush   = storeEvt & ~isFull;
  assign doPop    = (state == REQ) & CWACK;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stocPrev <= 1'b1;
      headPtr  <= 2'd0;
      tailPtr  <= 2'd0;
      count    <= 3'd0;
      wbOvf    <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      stocPrev <= STOC_n;
      if (doPush) begin
        mem[tailPtr] <= {CA_9_0, CD_15_0};
        tailPtr      <= tailPtr + 2'd1;
      end
      if (storeEvt && isFull) wbOvf <= 1'b1;
      if (doPop) headPtr <= headPtr + 2'd1;
      case ({doPush, doPop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // The head slot cannot be written while in REQ: a push only targets it when the buffer is full,
  // and pushes are refused when full. cramQ therefore keeps the head (or last popped entry) stable.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cwReq <= 1'b0;
      cramQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 3'd0) begin
            state <= REQ;
            cwReq <= 1'b1;
            cramQ <= mem[headPtr];
          end
        end
        REQ: begin
          if (CWACK) begin
            state <= RECOV;
            cwReq <= 1'b0;
          end
        end
        RECOV: begin
          state <= IDLE;
          cwReq <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cwReq <= 1'b0;
        end
      endcase
    end
  end

  assign CWREQ       = cwReq;
  assign CWE_n       = ~cwReq;
  assign CRAM_A_9_0  = cramQ[25:16];
  assign CRAM_D_15_0 = cramQ[15:0];
  assign WBFULL_n    = ~isFull;
  assign WBEMPTY     = (count == 3'd0);
  assign WBCNT_2_0   = count;
  assign WBOVF       = wbOvf;

endmodule

// File: tb/tb_cpu_stoc_wbuf.sv
// Bench for cpu_stoc_wbuf: directed vector table, hand sequences for reset/strobe corners,
// and a randomized run checked against a queue-based model of the buffer.
`timescale 1ns/1ps

module tb_cpu_stoc_wbuf;

  logic        sysclk;
  logic        sys_rst_n;
  logic        STOC_n;
  logic [15:0] CD_15_0;
  logic [9:0]  CA_9_0;
  logic        CWACK;
  logic        CWREQ;
  logic        CWE_n;
  logic [15:0] CRAM_D_15_0;
  logic [9:0]  CRAM_A_9_0;
  logic        WBFULL_n;
  logic        WBEMPTY;
  logic [2:0]  WBCNT_2_0;
  logic        WBOVF;

  int nChecks = 0;
  int nFail   = 0;

  cpu_stoc_wbuf dut (
    .sysclk      (sysclk),
    .sys_rst_n   (sys_rst_n),
    .STOC_n      (STOC_n),
    .CD_15_0     (CD_15_0),
    .CA_9_0      (CA_9_0),
    .CWACK       (CWACK),
    .CWREQ       (CWREQ),
    .CWE_n       (CWE_n),
    .CRAM_D_15_0 (CRAM_D_15_0),
    .CRAM_A_9_0  (CRAM_A_9_0),
    .WBFULL_n    (WBFULL_n),
    .WBEMPTY     (WBEMPTY),
    .WBCNT_2_0   (WBCNT_2_0),
    .WBOVF       (WBOVF)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        stocN;
    logic [9:0]  ca;
    logic [15:0] cd;
    logic        ack;
    logic [2:0]  expCnt;
    logic        expReq;
    logic        expOvf;
    logic [9:0]  expA;
    logic [15:0] expD;
  } vecT;

  function automatic vecT mk(logic stocN, logic [9:0] ca, logic [15:0] cd, logic ack,
                             logic [2:0] expCnt, logic expReq, logic expOvf,
                             logic [9:0] expA, logic [15:0] expD);
    vecT v;
    v.stocN = stocN; v.ca = ca; v.cd = cd; v.ack = ack;
    v.expCnt = expCnt; v.expReq = expReq; v.expOvf = expOvf; v.expA = expA; v.expD = expD;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chkStatus(input string tag, input logic [2:0] cnt);
    chk({tag, ".cnt"},   {29'd0, WBCNT_2_0}, {29'd0, cnt});
    chk({tag, ".fulln"}, {31'd0, WBFULL_n},  {31'd0, cnt != 3'd4});
    chk({tag, ".empty"}, {31'd0, WBEMPTY},   {31'd0, cnt == 3'd0});
  endtask

  vecT          vecs [24];
  logic [25:0]  q [$];
  logic [25:0]  inWord;
  logic         mPrev, evt, full, stocNow, ackNow, r1, r2, mOvf;
  int           szPrev;

  initial begin
    sys_rst_n = 1'b0;
    STOC_n    = 1'b1;
    CD_15_0   = '0;
    CA_9_0    = '0;
    CWACK     = 1'b0;

    // fill four, overflow with DEAD, drain 3 apart, push on a pop edge at count 2, wrap through slot 0
    vecs[0]  = mk(0, 10'h201, 16'h0001, 0, 1, 0, 0, 10'h000, 16'h0000);
    vecs[1]  = mk(1, 10'h000, 16'h0000, 0, 1, 1, 0, 10'h201, 16'h0001);
    vecs[2]  = mk(0, 10'h202, 16'h0002, 0, 2, 1, 0, 10'h201, 16'h0001);
    vecs[3]  = mk(1, 10'h000, 16'h0000, 0, 2, 1, 0, 10'h201, 16'h0001);
    vecs[4]  = mk(0, 10'h203, 16'h0003, 0, 3, 1, 0, 10'h201, 16'h0001);
    vecs[5]  = mk(1, 10'h000, 16'h0000, 0, 3, 1, 0, 10'h201, 16'h0001);
    vecs[6]  = mk(0, 10'h204, 16'h0004, 0, 4, 1, 0, 10'h201, 16'h0001);
    vecs[7]  = mk(1, 10'h000, 16'h0000, 0, 4, 1, 0, 10'h201, 16'h0001);
    vecs[8]  = mk(0, 10'h3FF, 16'hDEAD, 0, 4, 1, 1, 10'h201, 16'h0001);
    vecs[9]  = mk(1, 10'h000, 16'h0000, 1, 3, 0, 1, 10'h000, 16'h0000);
    vecs[10] = mk(1, 10'h000, 16'h0000, 1, 3, 0, 1, 10'h000, 16'h0000);
    vecs[11] = mk(1, 10'h000, 16'h0000, 1, 3, 1, 1, 10'h202, 16'h0002);
    vecs[12] = mk(1, 10'h000, 16'h0000, 1, 2, 0, 1, 10'h000, 16'h0000);
    vecs[13] = mk(1, 10'h000, 16'h0000, 1, 2, 0, 1, 10'h000, 16'h0000);
    vecs[14] = mk(1, 10'h000, 16'h0000, 1, 2, 1, 1, 10'h203, 16'h0003);
    vecs[15] = mk(0, 10'h205, 16'h0005, 1, 2, 0, 1, 10'h000, 16'h0000);
    vecs[16] = mk(1, 10'h000, 16'h0000, 1, 2, 0, 1, 10'h000, 16'h0000);
    vecs[17] = mk(1, 10'h000, 16'h0000, 1, 2, 1, 1, 10'h204, 16'h0004);
    vecs[18] = mk(1, 10'h000, 16'h0000, 1, 1, 0, 1, 10'h000, 16'h0000);
    vecs[19] = mk(1, 10'h000, 16'h0000, 1, 1, 0, 1, 10'h000, 16'h0000);
    vecs[20] = mk(1, 10'h000, 16'h0000, 1, 1, 1, 1, 10'h205, 16'h0005);
    vecs[21] = mk(1, 10'h000, 16'h0000, 1, 0, 0, 1, 10'h000, 16'h0000);
    vecs[22] = mk(1, 10'h000, 16'h0000, 1, 0, 0, 1, 10'h000, 16'h0000);
    vecs[23] = mk(1, 10'h000, 16'h0000, 1, 0, 0, 1, 10'h000, 16'h0000);

    #12;
    chk("rst.req",  {31'd0, CWREQ}, 32'd0);
    chk("rst.cwen", {31'd0, CWE_n}, 32'd1);
    chk("rst.ovf",  {31'd0, WBOVF}, 32'd0);
    chk("rst.cramD", {16'd0, CRAM_D_15_0}, 32'd0);
    chkStatus("rst", 3'd0);
    step();
    sys_rst_n = 1'b1;
    step();

    // single store with acknowledge tied high
    CWACK = 1'b1; CA_9_0 = 10'h155; CD_15_0 = 16'hA5C3; STOC_n = 1'b0;
    step();
    chkStatus("single.cap", 3'd1);
    chk("single.req0", {31'd0, CWREQ}, 32'd0);
    STOC_n = 1'b1; CD_15_0 = '0; CA_9_0 = '0;
    step();
    chk("single.req1", {31'd0, CWREQ}, 32'd1);
    chk("single.cramA", {22'd0, CRAM_A_9_0}, 32'h155);
    chk("single.cramD", {16'd0, CRAM_D_15_0}, 32'hA5C3);
    step();
    chk("single.req2", {31'd0, CWREQ}, 32'd0);
    chkStatus("single.pop", 3'd0);
    step();
    step();

    foreach (vecs[i]) begin
      STOC_n = vecs[i].stocN; CA_9_0 = vecs[i].ca; CD_15_0 = vecs[i].cd; CWACK = vecs[i].ack;
      step();
      chkStatus($sformatf("vec%0d", i), vecs[i].expCnt);
      chk($sformatf("vec%0d.req", i),  {31'd0, CWREQ}, {31'd0, vecs[i].expReq});
      chk($sformatf("vec%0d.cwen", i), {31'd0, CWE_n}, {31'd0, ~vecs[i].expReq});
      chk($sformatf("vec%0d.ovf", i),  {31'd0, WBOVF}, {31'd0, vecs[i].expOvf});
      chk($sformatf("vec%0d.noDead", i), {31'd0, CRAM_D_15_0 == 16'hDEAD}, 32'd0);
      if (vecs[i].expReq) begin
        chk($sformatf("vec%0d.cramA", i), {22'd0, CRAM_A_9_0},  {22'd0, vecs[i].expA});
        chk($sformatf("vec%0d.cramD", i), {16'd0, CRAM_D_15_0}, {16'd0, vecs[i].expD});
      end
    end

    // strobe held low for five cycles is one store
    CWACK = 1'b0; CA_9_0 = 10'h0AA; CD_15_0 = 16'h1234; STOC_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chkStatus($sformatf("long%0d", i), 3'd1);
    end
    STOC_n = 1'b1;
    step();
    chkStatus("long.end", 3'd1);
    chk("long.req", {31'd0, CWREQ}, 32'd1);

    // reset while a RAM write is in flight
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midRst.req",  {31'd0, CWREQ}, 32'd0);
    chk("midRst.cwen", {31'd0, CWE_n}, 32'd1);
    step();
    sys_rst_n = 1'b1;
    step();
    chkStatus("midRst.after", 3'd0);
    chk("midRst.ovf", {31'd0, WBOVF}, 32'd0);
    chk("midRst.req2", {31'd0, CWREQ}, 32'd0);

    // randomized traffic against the queue model
    q.delete();
    mPrev = 1'b1; mOvf = 1'b0;
    r1 = CWREQ; r2 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      STOC_n  = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      CWACK   = $urandom_range(0, 1) == 1;
      CD_15_0 = 16'($urandom);
      CA_9_0  = 10'($urandom);
      inWord  = {CA_9_0, CD_15_0};
      stocNow = STOC_n;
      ackNow  = CWACK;
      szPrev  = q.size();
      step();

      evt   = !stocNow && mPrev;
      mPrev = stocNow;
      full  = (q.size() == 4);
      if (r1 && ackNow && q.size() > 0) void'(q.pop_front());
      if (evt && !full) q.push_back(inWord);
      if (evt && full) mOvf = 1'b1;

      chkStatus("rnd", 3'(q.size()));
      chk("rnd.ovf",  {31'd0, WBOVF}, {31'd0, mOvf});
      chk("rnd.cwen", {31'd0, CWE_n}, {31'd0, ~CWREQ});
      if (r1 && !ackNow) chk("rnd.holdReq", {31'd0, CWREQ}, 32'd1);
      if (r1 && ackNow)  chk("rnd.recov",   {31'd0, CWREQ}, 32'd0);
      if (!r1 && !r2 && szPrev > 0) chk("rnd.startReq", {31'd0, CWREQ}, 32'd1);
      if (CWREQ && !r1) chk("rnd.gap", {31'd0, r2}, 32'd0);
      if (q.size() == 0)
        chk("rnd.reqEmpty", {31'd0, CWREQ}, 32'd0);
      else if (CWREQ)
        chk("rnd.head", {6'd0, CRAM_A_9_0, CRAM_D_15_0}, {6'd0, q[0]});
      r2 = r1;
      r1 = CWREQ;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
